length_sequencer: RTL

- Sits between the per-frame shadow detectors (centroid x0/y0, tip x/y, mass) and the shared multi-cycle `length` datapath.
- Captures one measurement per frame and issues it to `length` only when that unit is idle.
- Handles timeouts and frames dropped for lack of buffer space.
- Averages accepted lengths over 2^AVG_LOG2 frames to produce a stable shadow length for the time-of-day logic.

---
 rtl/sundial_pkg.sv | 25 ++
 rtl/length_avg.sv | 49 ++++
 rtl/length_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sundial_pkg.sv
// Shared types for the shadow-length sequencing path: FSM states, operand widths
// and the per-frame measurement record.
package sundial_pkg;

    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int MASS_W = 32;
    localparam int LEN_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACCUM
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]    x0;
        logic [Y_W-1:0]    y0;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [MASS_W-1:0] mass;
    } meas_t;

endpackage

// File: rtl/length_avg.sv
// Block averager: sums 2^AVG_LOG2 accepted lengths and publishes the truncated
// mean with a one-cycle strobe; the published value holds until the next block.
module length_avg
    import sundial_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sample_valid_in,
    input  logic [LEN_W-1:0] sample_in,
    output logic [LEN_W-1:0] avg_out,
    output logic             avg_valid_out
);

    localparam int ACC_W = LEN_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] sample_cnt;
    logic [ACC_W-1:0] sum;

    // Extra AVG_LOG2 bits make the full block sum overflow-free.
    assign sum = acc + ACC_W'(sample_in);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc           <= '0;
            sample_cnt    <= '0;
            avg_out       <= '0;
            avg_valid_out <= 1'b0;
        end else begin
            avg_valid_out <= 1'b0;
            if (sample_valid_in) begin
                if (sample_cnt == CNT_LAST) begin
                    avg_out       <= LEN_W'(sum >> AVG_LOG2);
                    avg_valid_out <= 1'b1;
                    acc           <= '0;
                    sample_cnt    <= '0;
                end else begin
                    acc        <= sum;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/length_sequencer.sv
// Captures one detector measurement per frame into a single pending slot and feeds
// it to the shared multi-cycle length unit, with timeout, drop counting and averaging.
//
//   state | meaning
//   IDLE  | waiting for a full slot; moves slot into operand registers
//   ISSUE | start pulse to the length unit, timer cleared
//   WAIT  | operands held, waiting for result or timeout
//   ACCUM | result handed to the averager
module length_sequencer
    import sundial_pkg::*;
#(
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DROP_W         = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_done_in,
    input  logic [X_W-1:0]    x0_in,
    input  logic [Y_W-1:0]    y0_in,
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    input  logic [MASS_W-1:0] mass_in,
    output logic              len_valid_out,
    output logic [X_W-1:0]    len_x0_out,
    output logic [Y_W-1:0]    len_y0_out,
    output logic [X_W-1:0]    len_x_out,
    output logic [Y_W-1:0]    len_y_out,
    output logic [MASS_W-1:0] len_mass_out,
    input  logic [LEN_W-1:0]  len_length_in,
    input  logic              len_valid_in,
    output logic [LEN_W-1:0]  avg_length_out,
    output logic              avg_valid_out,
    output logic              busy_out,
    output logic              timeout_out,
    output logic [DROP_W-1:0] drop_count_out
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    meas_t            slot;
    logic             slot_full;
    logic [TMR_W-1:0] timer;
    logic [LEN_W-1:0] length_q;
    logic             drain;
    logic             capture;
    logic             drop;
    logic             sample_valid;

    // A slot being drained this cycle can accept the next frame without loss.
    assign drain   = (state == IDLE) && slot_full;
    assign capture = frame_done_in && (mass_in != '0) && (!slot_full || drain);
    assign drop    = frame_done_in && (mass_in != '0) && slot_full && !drain;

    assign busy_out     = (state != IDLE);
    assign sample_valid = (state == ACCUM);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_full      <= 1'b0;
            slot           <= '0;
            drop_count_out <= '0;
        end else begin
            if (capture) begin
                slot_full <= 1'b1;
                slot      <= {x0_in, y0_in, x_in, y_in, mass_in};
            end else if (drain) begin
                slot_full <= 1'b0;
            end
            if (drop && (drop_count_out != '1)) begin
                drop_count_out <= drop_count_out + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            len_valid_out <= 1'b0;
            len_x0_out    <= '0;
            len_y0_out    <= '0;
            len_x_out     <= '0;
            len_y_out     <= '0;
            len_mass_out  <= '0;
            timeout_out   <= 1'b0;
            timer         <= '0;
            length_q      <= '0;
        end else begin
            len_valid_out <= 1'b0;
            timeout_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (slot_full) begin
                        len_x0_out    <= slot.x0;
                        len_y0_out    <= slot.y0;
                        len_x_out     <= slot.x;
                        len_y_out     <= slot.y;
                        len_mass_out  <= slot.mass;
                        len_valid_out <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle still wins over the timeout.
                    if (len_valid_in) begin
                        length_q <= len_length_in;
                        state    <= ACCUM;
                    end else if (timer == TMR_LAST) begin
                        timeout_out <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACCUM: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    length_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_length_avg (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .sample_valid_in(sample_valid),
        .sample_in      (length_q),
        .avg_out        (avg_length_out),
        .avg_valid_out  (avg_valid_out)
    );

endmodule
